// File: rtl/dac_bram_player.sv
// Playback sequencer: loops BRAM words [start_idx, stop_idx) onto a 512-bit AXIS master
// while enable is high, with credit-based read issue and a registered output stage.
module dac_bram_player #(
  parameter int unsigned DATA_W     = 512,
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned RD_LAT     = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              enable,
  input  logic [31:0]       start_ptr,
  input  logic [31:0]       stop_ptr,
  output logic              bram_en,
  output logic [ADDR_W-1:0] bram_addr,
  input  logic [DATA_W-1:0] bram_dout,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              busy,
  output logic              cfg_err,
  output logic [31:0]       loop_count
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + RD_LAT + 2);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_next;

  logic              enable_q;
  logic [ADDR_W-1:0] start_in, stop_in, start_idx, stop_idx, rd_ptr;
  logic [RD_LAT-1:0] vld;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_idx, rd_idx;
  logic [CW-1:0]     fifo_count, inflight;
  logic              rise, n_ok, running, credit, issue, ret, load, fifo_push, fifo_pop;
  logic              unused_ptr_bits;

  assign start_in        = start_ptr[ADDR_W+5:6];
  assign stop_in         = stop_ptr[ADDR_W+5:6];
  assign unused_ptr_bits = ^{start_ptr[31:ADDR_W+6], start_ptr[5:0], stop_ptr[31:ADDR_W+6], stop_ptr[5:0]};

  always_comb begin
    inflight = CW'(bram_en);
    for (int unsigned i = 0; i < RD_LAT; i++) inflight = inflight + CW'(vld[i]);
  end

  assign rise      = enable & ~enable_q;
  assign n_ok      = stop_in > start_in;
  assign running   = (state == RUN) & enable;
  assign credit    = (fifo_count + inflight) < CW'(FIFO_DEPTH);
  assign issue     = running & credit;
  assign ret       = running & vld[RD_LAT-1];
  assign load      = ~m_axis_tvalid | m_axis_tready;
  assign fifo_pop  = running & load & (fifo_count != '0);
  assign fifo_push = ret & ~(load & (fifo_count == '0));

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (rise && n_ok) state_next = RUN;
      RUN:     if (!enable) state_next = DRAIN;
      DRAIN:   if ((inflight == '0) && load) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  // enable_q resets high so a level already asserted across reset is not a new start
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      enable_q   <= 1'b1;
      start_idx  <= '0;
      stop_idx   <= '0;
      rd_ptr     <= '0;
      bram_en    <= 1'b0;
      bram_addr  <= '0;
      vld        <= '0;
      cfg_err    <= 1'b0;
      loop_count <= '0;
    end else begin
      enable_q <= enable;
      bram_en  <= issue;
      vld[0]   <= bram_en;
      for (int unsigned i = 1; i < RD_LAT; i++) vld[i] <= vld[i-1];
      if (state == IDLE && rise) begin
        start_idx <= start_in;
        stop_idx  <= stop_in;
        if (n_ok) begin
          rd_ptr     <= start_in;
          loop_count <= '0;
          cfg_err    <= 1'b0;
        end else begin
          cfg_err <= 1'b1;
        end
      end
      if (issue) begin
        bram_addr <= rd_ptr;
        if (rd_ptr == stop_idx - ADDR_W'(1)) begin
          rd_ptr     <= start_idx;
          loop_count <= loop_count + 32'd1;
        end else begin
          rd_ptr <= rd_ptr + ADDR_W'(1);
        end
      end
    end
  end

  // Returned data bypasses the FIFO straight into the output register when it is free
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      wr_idx        <= '0;
      rd_idx        <= '0;
      fifo_count    <= '0;
    end else if (running) begin
      if (load) begin
        if (fifo_count != '0) begin
          m_axis_tdata  <= mem[rd_idx];
          m_axis_tvalid <= 1'b1;
        end else if (ret) begin
          m_axis_tdata  <= bram_dout;
          m_axis_tvalid <= 1'b1;
        end else begin
          m_axis_tvalid <= 1'b0;
        end
      end
      if (fifo_push) wr_idx <= (wr_idx == PW'(FIFO_DEPTH - 1)) ? '0 : wr_idx + PW'(1);
      if (fifo_pop)  rd_idx <= (rd_idx == PW'(FIFO_DEPTH - 1)) ? '0 : rd_idx + PW'(1);
      case ({fifo_push, fifo_pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end else begin
      if (load) m_axis_tvalid <= 1'b0;
      wr_idx     <= '0;
      rd_idx     <= '0;
      fifo_count <= '0;
    end
  end

  always_ff @(posedge aclk) begin
    if (fifo_push) mem[wr_idx] <= bram_dout;
  end

  push_not_full: assert property (@(posedge aclk) disable iff (!aresetn)
    !(fifo_push && (fifo_count == CW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_dac_bram_player.sv
// Directed bench for dac_bram_player: vector table of playback runs plus drain and reset sequences.
module tb_dac_bram_player;
  localparam int unsigned DATA_W = 512, ADDR_W = 12, RD_LAT = 2, FIFO_DEPTH = 4;

  logic              aclk = 1'b0, aresetn = 1'b0, enable = 1'b0;
  logic [31:0]       start_ptr = '0, stop_ptr = '0;
  logic              bram_en;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_dout;
  logic [DATA_W-1:0] tdata;
  logic              tvalid, tready = 1'b0, busy, cfg_err;
  logic [31:0]       loop_count;

  dac_bram_player #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .aclk(aclk), .aresetn(aresetn), .enable(enable), .start_ptr(start_ptr), .stop_ptr(stop_ptr),
    .bram_en(bram_en), .bram_addr(bram_addr), .bram_dout(bram_dout),
    .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
    .busy(busy), .cfg_err(cfg_err), .loop_count(loop_count));

  always #5 aclk = ~aclk;

  function automatic logic [DATA_W-1:0] word(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = 32'hD0C0_0000 + (32'(a) << 8) + 32'(i);
    return r;
  endfunction

  // Two-stage BRAM read pipeline
  logic [DATA_W-1:0] s1 = '0, s2 = '0;
  always @(posedge aclk) begin
    if (bram_en) s1 <= word(bram_addr);
    s2 <= s1;
  end
  assign bram_dout = s2;

  int checks = 0, errors = 0;
  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [ADDR_W-1:0] m_start, m_stop, exp_rd, exp_beat;
  int                issued, accepted;
  bit                mon_run = 0, prev_stall = 0;
  logic [DATA_W-1:0] prev_data;

  function automatic logic [ADDR_W-1:0] next_idx(input logic [ADDR_W-1:0] a);
    return (a == m_stop - ADDR_W'(1)) ? m_start : a + ADDR_W'(1);
  endfunction

  task automatic model_start(input logic [31:0] sp, input logic [31:0] ep, input bit run);
    m_start  = sp[ADDR_W+5:6];
    m_stop   = ep[ADDR_W+5:6];
    exp_rd   = m_start;
    exp_beat = m_start;
    issued   = 0;
    accepted = 0;
    mon_run  = run;
  endtask

  // Sampled mid-cycle: tvalid/tready seen here are what the next rising edge acts on
  always @(negedge aclk) begin
    if (!aresetn) prev_stall = 0;
    else begin
      if (prev_stall) begin
        chk("stall_valid", tvalid, 1);
        chk("stall_data", tdata, prev_data);
      end
      if (bram_en) begin
        chk("bram_addr", bram_addr, exp_rd);
        exp_rd = next_idx(exp_rd);
        issued++;
      end
      if (tvalid && tready) begin
        chk("beat_data", tdata, word(exp_beat));
        exp_beat = next_idx(exp_beat);
        accepted++;
      end
      if (mon_run) chk("outstanding", ((issued - accepted) <= int'(FIFO_DEPTH) + 1), 1);
      prev_stall = tvalid && !tready;
      prev_data  = tdata;
    end
  end

  typedef struct {
    logic [31:0] sp;
    logic [31:0] ep;
    bit          rnd;
    int          cycles;
    bit          err;
    logic [31:0] exp_loop;
  } vec_t;
  vec_t vecs[7];

  task automatic drain_to_idle();
    @(posedge aclk); #1;
    enable  = 0;
    tready  = 1;
    mon_run = 0;
    for (int i = 0; i < 20 && busy; i++) begin
      @(negedge aclk); #1;
    end
    chk("drain_busy", busy, 0);
    chk("drain_tvalid", tvalid, 0);
  endtask

  task automatic run_vec(input vec_t v);
    int bad = 0;
    model_start(v.sp, v.ep, !v.err);
    @(posedge aclk); #1;
    start_ptr = v.sp;
    stop_ptr  = v.ep;
    enable    = 1;
    tready    = 1;
    @(posedge aclk); #1;
    for (int k = 0; k <= v.cycles; k++) begin
      if (k > 0) begin
        @(posedge aclk); #1;
      end
      if (v.rnd) tready = 1'($urandom_range(0, 1));
      @(negedge aclk); #1;
      if (k == 0 && !v.err) chk("lc_clear", loop_count, 0);
      if (k == 1) chk("first_en", bram_en, !v.err);
      if (!v.err && k == 3) chk("tvalid_e3", tvalid, 0);
      if (!v.err && k == 4) chk("tvalid_e4", tvalid, 1);
      if (!v.err && !v.rnd && k >= 4 && !tvalid) bad++;
      if (v.err && (tvalid || busy)) bad++;
    end
    if (!v.err && !v.rnd) chk("loop_count", loop_count, v.exp_loop);
    if (!v.err && v.rnd) chk("loop_model", loop_count, 32'(issued / int'(m_stop - m_start)));
    chk("cfg_err", cfg_err, v.err);
    chk("busy", busy, !v.err);
    if (v.err) chk("err_no_reads", issued, 0);
    chk(v.err ? "err_quiet" : "bubbles", bad, 0);
    drain_to_idle();
  endtask

  initial begin
    vecs[0] = '{32'h000, 32'h080, 1'b0, 6,   1'b0, 32'd3};
    vecs[1] = '{32'h000, 32'hC00, 1'b0, 192, 1'b0, 32'd4};
    vecs[2] = '{32'h100, 32'h100, 1'b0, 10,  1'b1, 32'd0};
    vecs[3] = '{32'h100, 32'h0C0, 1'b0, 10,  1'b1, 32'd0};
    vecs[4] = '{32'h040, 32'h080, 1'b0, 5,   1'b0, 32'd5};
    vecs[5] = '{32'h07F, 32'h0C5, 1'b0, 4,   1'b0, 32'd2};
    vecs[6] = '{32'h000, 32'h080, 1'b1, 60,  1'b0, 32'd0};

    #1;
    chk("rst_bram_en", bram_en, 0);
    chk("rst_bram_addr", bram_addr, 0);
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_loop_count", loop_count, 0);
    repeat (3) @(posedge aclk);
    #2 aresetn = 1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Enable dropped while a beat is stalled: that beat alone is delivered, then restart
    model_start(32'h040, 32'h0C0, 1);
    @(posedge aclk); #1;
    start_ptr = 32'h040;
    stop_ptr  = 32'h0C0;
    tready    = 0;
    enable    = 1;
    repeat (11) @(posedge aclk);
    @(negedge aclk); #1;
    chk("stall_tvalid", tvalid, 1);
    chk("credit_limit", issued, 5);
    chk("stall_loops", loop_count, 2);
    @(posedge aclk); #1;
    enable  = 0;
    mon_run = 0;
    repeat (4) @(posedge aclk);
    @(negedge aclk); #1;
    chk("held_tvalid", tvalid, 1);
    chk("held_busy", busy, 1);
    chk("held_none_taken", accepted, 0);
    @(posedge aclk); #1;
    tready = 1;
    repeat (6) @(posedge aclk);
    @(negedge aclk); #1;
    chk("held_delivered_once", accepted, 1);
    chk("post_drain_tvalid", tvalid, 0);
    chk("post_drain_busy", busy, 0);
    model_start(32'h040, 32'h0C0, 1);
    @(posedge aclk); #1;
    enable = 1;
    @(posedge aclk);
    @(negedge aclk); #1;
    chk("restart_lc", loop_count, 0);
    chk("restart_busy", busy, 1);
    repeat (4) @(posedge aclk);
    @(negedge aclk); #1;
    chk("restart_tvalid", tvalid, 1);
    chk("restart_first_beat", tdata, word(ADDR_W'(1)));
    drain_to_idle();

    // Asynchronous reset mid-stream, enable kept high through and after it
    model_start(32'h000, 32'h080, 1);
    @(posedge aclk); #1;
    start_ptr = 32'h000;
    stop_ptr  = 32'h080;
    enable    = 1;
    repeat (8) @(posedge aclk);
    @(negedge aclk); #1;
    chk("pre_rst_tvalid", tvalid, 1);
    #1 aresetn = 0;
    mon_run = 0;
    #1;
    chk("async_tvalid", tvalid, 0);
    chk("async_busy", busy, 0);
    chk("async_bram_en", bram_en, 0);
    @(negedge aclk); #2;
    aresetn = 1;
    issued  = 0;
    repeat (10) @(posedge aclk);
    @(negedge aclk); #1;
    chk("no_restart_reads", issued, 0);
    chk("no_restart_tvalid", tvalid, 0);
    chk("no_restart_busy", busy, 0);
    @(posedge aclk); #1;
    enable = 0;
    run_vec(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
